// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
interface hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_br_taken;
    logic        ex_matrix_start;
    logic        matrix_done;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mat_timeout;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Pipeline side: drives hazard sources, receives stall/flush controls
    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
               ex_br_taken, ex_matrix_start, matrix_done,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_flush,
               mat_timeout, stall_cnt, flush_cnt
    );

    // Controller side
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
               ex_br_taken, ex_matrix_start, matrix_done,
        output pc_stall, if_id_stall, if_id_flush, id_ex_flush,
               mat_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller with matrix-unit watchdog (optional stats: HAZARD_STAT_EN)
module hazard_ctrl #(
    parameter int MAT_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);

    localparam int WD_W = (MAT_TIMEOUT > 1) ? $clog2(MAT_TIMEOUT) : 1;

    typedef enum logic {
        RUN      = 1'b0,
        MAT_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WD_W-1:0] r_wd;
    logic            r_mat_timeout;

    logic w_load_use;
    logic w_pc_stall;
    logic w_if_id_stall;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_wd_clr;
    logic w_wd_inc;
    logic w_timeout;

    assign w_load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                        ((bus.ex_rd == bus.id_rs1) ||
                         (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));

    // Next state and control outputs; controls are forced low while rst is held
    always_comb begin
        w_next        = r_state;
        w_pc_stall    = 1'b0;
        w_if_id_stall = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_wd_clr      = 1'b0;
        w_wd_inc      = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.ex_br_taken) begin
                    // Taken branch squashes both younger stages; it wins over everything
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (bus.ex_matrix_start) begin
                    w_pc_stall    = 1'b1;
                    w_if_id_stall = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_wd_clr      = 1'b1;
                    w_next        = MAT_BUSY;
                end else if (w_load_use) begin
                    w_pc_stall    = 1'b1;
                    w_if_id_stall = 1'b1;
                    w_id_ex_flush = 1'b1;
                end
            end
            MAT_BUSY: begin
                // Done beats the watchdog when both land in the same cycle
                if (bus.matrix_done) begin
                    w_next = RUN;
                end else begin
                    w_pc_stall    = 1'b1;
                    w_if_id_stall = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_wd_inc      = 1'b1;
                    if (r_wd == WD_W'(MAT_TIMEOUT - 1)) begin
                        w_timeout = 1'b1;
                        w_next    = RUN;
                    end
                end
            end
            default: w_next = RUN;
        endcase
        if (rst) begin
            w_pc_stall    = 1'b0;
            w_if_id_stall = 1'b0;
            w_if_id_flush = 1'b0;
            w_id_ex_flush = 1'b0;
            w_timeout     = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Watchdog: cleared on matrix start, counts busy cycles without done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd <= '0;
        end else if (w_wd_clr) begin
            r_wd <= '0;
        end else if (w_wd_inc) begin
            r_wd <= r_wd + WD_W'(1);
        end
    end

    // One-cycle registered timeout pulse, following the abort cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mat_timeout <= 1'b0;
        end else begin
            r_mat_timeout <= w_timeout;
        end
    end

    assign bus.pc_stall    = w_pc_stall;
    assign bus.if_id_stall = w_if_id_stall;
    assign bus.if_id_flush = w_if_id_flush;
    assign bus.id_ex_flush = w_id_ex_flush;
    assign bus.mat_timeout = r_mat_timeout;

`ifdef HAZARD_STAT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating stall/flush cycle counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_pc_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_if_id_flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`else
    assign bus.stall_cnt = 32'd0;
    assign bus.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

`ifdef HAZARD_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    // exp = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, mat_timeout}
    localparam logic [4:0] Z = 5'b00000;
    localparam logic [4:0] S = 5'b11010;
    localparam logic [4:0] F = 5'b00110;
    localparam logic [4:0] T = 5'b00001;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs2;
        logic [4:0] rd;
        logic       mem_read;
        logic       br;
        logic       mstart;
        logic       mdone;
        logic [4:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    vec_t sb_q[$];
    vec_t tbl[12];

    hazard_ctrl_if ifa ();
    hazard_ctrl_if ifb ();

    hazard_ctrl #(.MAT_TIMEOUT(64)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    hazard_ctrl #(.MAT_TIMEOUT(4))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                                input logic [4:0] rd, input logic mem, input logic br,
                                input logic ms, input logic md, input logic [4:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.uses_rs2 = uses; v.rd = rd; v.mem_read = mem;
        v.br = br; v.mstart = ms; v.mdone = md; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ifa.id_rs1 = v.rs1;        ifb.id_rs1 = v.rs1;
        ifa.id_rs2 = v.rs2;        ifb.id_rs2 = v.rs2;
        ifa.id_uses_rs2 = v.uses_rs2; ifb.id_uses_rs2 = v.uses_rs2;
        ifa.ex_rd = v.rd;          ifb.ex_rd = v.rd;
        ifa.ex_mem_read = v.mem_read; ifb.ex_mem_read = v.mem_read;
        ifa.ex_br_taken = v.br;    ifb.ex_br_taken = v.br;
        ifa.ex_matrix_start = v.mstart; ifb.ex_matrix_start = v.mstart;
        ifa.matrix_done = v.mdone; ifb.matrix_done = v.mdone;
    endtask

    function automatic logic [4:0] ctl(input bit sel);
        if (sel)
            return {ifb.pc_stall, ifb.if_id_stall, ifb.if_id_flush, ifb.id_ex_flush, ifb.mat_timeout};
        return {ifa.pc_stall, ifa.if_id_stall, ifa.if_id_flush, ifa.id_ex_flush, ifa.mat_timeout};
    endfunction

    // Drive one cycle of stimulus, check outputs mid-cycle, end just after the next edge
    task automatic step(input bit sel, input string name, input vec_t v);
        vec_t e;
        drive(v);
        sb_q.push_back(v);
        @(negedge clk);
        e = sb_q.pop_front();
        chk(name, {27'd0, ctl(sel)}, {27'd0, e.exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, Z));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;

        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, Z);
        tbl[1]  = mk(5, 0, 0, 5, 1, 0, 0, 0, S);
        tbl[2]  = mk(5, 0, 0, 5, 0, 0, 0, 0, Z);
        tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0, Z);
        tbl[4]  = mk(1, 7, 0, 7, 1, 0, 0, 0, Z);
        tbl[5]  = mk(1, 7, 1, 7, 1, 0, 0, 0, S);
        tbl[6]  = mk(5, 0, 0, 6, 1, 0, 0, 0, Z);
        tbl[7]  = mk(3, 0, 0, 3, 1, 1, 1, 0, F);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, Z);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 0, F);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, Z);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, Z);

        // Reset state, with a load-use hazard presented while rst is held
        drive(mk(5, 0, 0, 5, 1, 0, 0, 0, Z));
        @(negedge clk);
        chk("rst_ctl", {27'd0, ctl(0)}, 32'd0);
        chk("rst_stall_cnt", ifa.stall_cnt, 32'd0);
        chk("rst_flush_cnt", ifa.flush_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Combinational RUN-state vectors
        for (int i = 0; i < 12; i++) begin
            step(1'b0, $sformatf("vec%0d", i), tbl[i]);
        end
        chk("tbl_stall_cnt", ifa.stall_cnt, STAT ? 32'd2 : 32'd0);
        chk("tbl_flush_cnt", ifa.flush_cnt, STAT ? 32'd2 : 32'd0);

        // Matrix op: start + 10 busy cycles stalled, released in the done cycle
        do_reset();
        step(1'b0, "mat_start", mk(0, 0, 0, 0, 0, 0, 1, 0, S));
        for (int i = 0; i < 10; i++) begin
            if (i == 2)
                step(1'b0, $sformatf("mat_busy%0d", i), mk(0, 0, 0, 0, 0, 1, 0, 0, S));
            else if (i == 4)
                step(1'b0, $sformatf("mat_busy%0d", i), mk(5, 0, 0, 5, 1, 0, 0, 0, S));
            else
                step(1'b0, $sformatf("mat_busy%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, S));
        end
        step(1'b0, "mat_done", mk(0, 0, 0, 0, 0, 0, 0, 1, Z));
        chk("mat_stall_cnt", ifa.stall_cnt, STAT ? 32'd11 : 32'd0);
        chk("mat_flush_cnt", ifa.flush_cnt, 32'd0);
        step(1'b0, "mat_after", mk(0, 0, 0, 0, 0, 0, 0, 0, Z));
        step(1'b0, "mat_run_lu", mk(5, 0, 0, 5, 1, 0, 0, 0, S));

        // Watchdog (MAT_TIMEOUT=4): abort after 4 busy cycles, one-cycle pulse
        do_reset();
        step(1'b1, "wd_start", mk(0, 0, 0, 0, 0, 0, 1, 0, S));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, $sformatf("wd_busy%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, S));
        end
        step(1'b1, "wd_pulse", mk(0, 0, 0, 0, 0, 0, 0, 0, T));
        step(1'b1, "wd_pulse_end", mk(0, 0, 0, 0, 0, 0, 0, 0, Z));
        chk("wd_stall_cnt", ifb.stall_cnt, STAT ? 32'd5 : 32'd0);

        // Done on the 4th busy cycle beats the watchdog: no pulse
        do_reset();
        step(1'b1, "wd2_start", mk(0, 0, 0, 0, 0, 0, 1, 0, S));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, $sformatf("wd2_busy%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, S));
        end
        step(1'b1, "wd2_done", mk(0, 0, 0, 0, 0, 0, 0, 1, Z));
        step(1'b1, "wd2_nopulse", mk(0, 0, 0, 0, 0, 0, 0, 0, Z));
        step(1'b1, "wd2_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, Z));

        // Reset pulsed between edges while busy
        do_reset();
        step(1'b0, "mr_start", mk(0, 0, 0, 0, 0, 0, 1, 0, S));
        step(1'b0, "mr_busy0", mk(0, 0, 0, 0, 0, 0, 0, 0, S));
        step(1'b0, "mr_busy1", mk(5, 0, 0, 5, 1, 0, 0, 0, S));
        #2;
        rst = 1'b1;
        #1;
        chk("mr_rst_ctl", {27'd0, ctl(0)}, 32'd0);
        chk("mr_rst_stall_cnt", ifa.stall_cnt, 32'd0);
        chk("mr_rst_flush_cnt", ifa.flush_cnt, 32'd0);
        rst = 1'b0;
        step(1'b0, "mr_run_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, Z));
        step(1'b0, "mr_run_lu", mk(5, 0, 0, 5, 1, 0, 0, 0, S));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MAT_TIMEOUT, default 64: maximum matrix-busy cycles before the watchdog aborts.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset; asynchronous, active-high.
REQ-004 SHALL have port id_rs1, input, 5: rs1 index of the instruction in ID.
REQ-005 SHALL have port id_rs2, input, 5: rs2 index of the instruction in ID.
REQ-006 SHALL have port id_uses_rs2, input, 1: the ID instruction reads rs2.
REQ-007 SHALL have port ex_rd, input, 5: destination index latched in ID/EX.
REQ-008 SHALL have port ex_mem_read, input, 1: the EX instruction is a load.
REQ-009 SHALL have port ex_br_taken, input, 1: the branch resolved in EX is taken.
REQ-010 SHALL have port ex_matrix_start, input, 1: a matrix op in EX starts this cycle.
REQ-011 SHALL have port matrix_done, input, 1: the matrix unit finished.
REQ-012 SHALL have port pc_stall, output, 1: hold PC.
REQ-013 SHALL have port if_id_stall, output, 1: hold the IF/ID register.
REQ-014 SHALL have port if_id_flush, output, 1: clear the IF/ID register.
REQ-015 SHALL have port id_ex_flush, output, 1: clear the ID/EX register (bubble).
REQ-016 SHALL have port mat_timeout, output, 1: registered one-cycle watchdog pulse.
REQ-017 SHALL have port stall_cnt, output, 32: count of stall cycles.
REQ-018 SHALL have port flush_cnt, output, 32: count of flush cycles.

Function
REQ-019 SHALL implement a 2-state FSM: RUN, MAT_BUSY.
REQ-020 SHALL define load_use = ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
REQ-021 In RUN, SHALL drive outputs combinationally with priority ex_br_taken > ex_matrix_start > load_use.
REQ-022 RUN with ex_br_taken: if_id_flush=1, id_ex_flush=1, no stall; ex_matrix_start and load_use are ignored; state stays RUN.
REQ-023 RUN with ex_matrix_start (no branch): pc_stall=if_id_stall=id_ex_flush=1; next state MAT_BUSY; watchdog counter cleared to 0.
REQ-024 RUN with load_use only: pc_stall=if_id_stall=id_ex_flush=1 for that cycle only; state stays RUN.
REQ-025 RUN with no condition: all control outputs 0.
REQ-026 MAT_BUSY without matrix_done: pc_stall=if_id_stall=id_ex_flush=1; watchdog counter +1 per cycle; ex_br_taken and load_use are ignored.
REQ-027 MAT_BUSY with matrix_done: all control outputs 0 that cycle; next state RUN.
REQ-028 MAT_BUSY without matrix_done and with watchdog==MAT_TIMEOUT-1: stall outputs stay 1 that cycle; next state RUN; mat_timeout=1 on the following cycle only.
REQ-029 SHALL give matrix_done precedence over timeout when both occur in the same cycle; no mat_timeout pulse is then produced.
REQ-030 SHALL ignore matrix_done while in RUN.

Reset
REQ-031 SHALL on rst, immediately and regardless of clk, enter RUN and clear the watchdog, mat_timeout, stall_cnt and flush_cnt to 0.
REQ-032 SHALL hold all control outputs at 0 while rst=1, including a reset asserted mid-MAT_BUSY.

Configuration
REQ-033 With HAZARD_STAT_EN defined, stall_cnt SHALL increment each cycle pc_stall=1 and flush_cnt SHALL increment each cycle if_id_flush=1, both saturating at 32'hFFFFFFFF.
REQ-034 Without HAZARD_STAT_EN, stall_cnt and flush_cnt SHALL be tied to 0 and no counter registers are built; ports stay present.

Verification
REQ-035 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 for one cycle -> stall+id_ex_flush=1 exactly 1 cycle; ex_rd=0 with id_rs1=0 -> no stall.
REQ-036 rs2 gating: ex_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall; id_uses_rs2=1 -> stall.
REQ-037 Branch priority: ex_br_taken=1 together with load_use and ex_matrix_start -> only flushes asserted; state stays RUN; flush_cnt+1 (HAZARD_STAT_EN).
REQ-038 Matrix: start, matrix_done after 10 cycles -> stall high for 11 cycles (start cycle plus 10 busy cycles) and low in the done cycle; stall_cnt=11.
REQ-039 Watchdog, MAT_TIMEOUT=4: start, never done -> RUN after 4 busy cycles; mat_timeout pulses 1 cycle; done on the 4th busy cycle -> no pulse.
REQ-040 Reset mid-MAT_BUSY: rst pulsed between edges -> outputs 0 at once; state RUN; counters 0.
